// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for RAM burst readers: FSM state encoding common to
// the RTL, its benches and future burst blocks.
package ram_burst_reader_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Valid/ready word stream carrying RAM burst data to a downstream consumer.
interface ram_burst_reader_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/xilinx_one_port_ram_async.sv
// Single-port RAM with synchronous write and asynchronous (combinational) read.
module xilinx_one_port_ram_async #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            ram[addr] <= din;
    end

    assign dout = ram[addr];
endmodule

// File: rtl/ram_burst_reader.sv
// Walks an async-read RAM from base_addr for len words and streams them out
// on a valid/ready interface at one word per cycle.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    ram_burst_reader_if.master    m,
    output logic                  busy,
    output logic                  done_tick
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH:0]   rem_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  valid_reg;
    logic                  slot_free;

    // The output slot can take a new word if empty or being drained this edge.
    assign slot_free = !valid_reg || m.m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_reg  <= '0;
            rem_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            if (state != READ && valid_reg && m.m_ready)
                valid_reg <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        addr_reg <= base_addr;
                        rem_reg  <= len;
                        state    <= (len == LEN_ZERO) ? DONE : READ;
                    end
                end
                READ: begin
                    // A simultaneous handshake and load keeps valid_reg set.
                    if (slot_free) begin
                        data_reg  <= ram_dout;
                        valid_reg <= 1'b1;
                        addr_reg  <= addr_reg + ADDR_ONE;
                        rem_reg   <= rem_reg - LEN_ONE;
                        if (rem_reg == LEN_ONE)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (valid_reg && m.m_ready)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ram_addr  = addr_reg;
    assign m.m_data  = data_reg;
    assign m.m_valid = valid_reg;
    assign busy      = (state != IDLE);
    assign done_tick = (state == DONE);
endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: queue-based stream model plus literal
// expectations for each scenario, checked against a real async RAM instance.
module tb_ram_burst_reader;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 2**AW;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic          busy;
    logic          done_tick;

    logic          we;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_din;
    logic [AW-1:0] ram_a;

    ram_burst_reader_if #(.DATA_WIDTH(DW)) m_if ();

    ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .m         (m_if.master),
        .busy      (busy),
        .done_tick (done_tick)
    );

    assign ram_a = busy ? ram_addr : tb_addr;

    xilinx_one_port_ram_async #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
        .clk  (clk),
        .we   (we),
        .addr (ram_a),
        .din  (tb_din),
        .dout (ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int d0 = 0;
    int s_cyc = 0;

    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    int            got_cyc [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit   [5:0]    bp_pat = 6'b101001;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Stream monitor: every accepted beat must be the next word the model expects.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, m_if.m_valid}, 32'd1);
                check("stall_data", {24'd0, m_if.m_data}, {24'd0, prev_data});
            end
            if (m_if.m_valid && m_if.m_ready) begin
                got_q.push_back(m_if.m_data);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got data %0h, required no beat (cycle %0d)", m_if.m_data, cyc);
                end else begin
                    check("beat_data", {24'd0, m_if.m_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (done_tick) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_pending_words", exp_q.size(), 32'd0);
                check("busy_at_done", {31'd0, busy}, 32'd1);
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_data  = m_if.m_data;
        end
    end

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            tb_addr = i[AW-1:0];
            tb_din  = 8'h10 + i[DW-1:0];
            mem_m[i] = 8'h10 + i[DW-1:0];
            we = 1'b1;
            @(posedge clk); #1;
        end
        we = 1'b0;
    endtask

    task automatic start_burst(input int b, input int l);
        for (int i = 0; i < l; i++) exp_q.push_back(mem_m[(b + i) % DEPTH]);
        got_q.delete();
        got_cyc.delete();
        d0 = done_cnt;
        start = 1'b1;
        base_addr = b[AW-1:0];
        len = l[AW:0];
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int limit, input bit bp);
        int k;
        k = 0;
        while (done_cnt == d0 && k < limit) begin
            if (bp) m_if.m_ready = bp_pat[k % 6];
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done_tick within %0d cycles, required one", limit);
        end
        m_if.m_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        m_if.m_ready = 1'b1;
        we = 1'b0;
        tb_addr = '0;
        tb_din = '0;
        #3;
        check("reset_ram_addr", {28'd0, ram_addr}, 32'd0);
        check("reset_m_data", {24'd0, m_if.m_data}, 32'd0);
        check("reset_m_valid", {31'd0, m_if.m_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done_tick}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        preload();

        // Full-rate burst: 0x13..0x17 on consecutive cycles, done one cycle later.
        start_burst(3, 5);
        wait_done(30, 1'b0);
        check("t1_beats", got_q.size(), 32'd5);
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            check("t1_data", {24'd0, got_q[i]}, 32'h13 + i);
            check("t1_beat_cycle", got_cyc[i], s_cyc + 1 + i);
        end
        check("t1_done_cycle", done_cyc, s_cyc + 6);
        check("t1_idle_after", {31'd0, busy}, 32'd0);

        // Wrap-around: addresses 14,15,0,1.
        start_burst(14, 4);
        wait_done(30, 1'b0);
        check("t2_beats", got_q.size(), 32'd4);
        if (got_q.size() == 4) begin
            check("t2_w0", {24'd0, got_q[0]}, 32'h1E);
            check("t2_w1", {24'd0, got_q[1]}, 32'h1F);
            check("t2_w2", {24'd0, got_q[2]}, 32'h10);
            check("t2_w3", {24'd0, got_q[3]}, 32'h11);
        end

        // Zero length: busy and done for exactly one cycle, no valid.
        start_burst(2, 0);
        check("t3_done_now", {31'd0, done_tick}, 32'd1);
        check("t3_valid_low", {31'd0, m_if.m_valid}, 32'd0);
        @(posedge clk); #1;
        check("t3_busy_gone", {31'd0, busy}, 32'd0);
        check("t3_done_gone", {31'd0, done_tick}, 32'd0);
        check("t3_valid_still_low", {31'd0, m_if.m_valid}, 32'd0);
        check("t3_done_count", done_cnt, d0 + 1);

        // Backpressure: m_ready follows 1,0,0,1,0,1...
        start_burst(0, 6);
        wait_done(60, 1'b1);
        check("t4_beats", got_q.size(), 32'd6);
        for (int i = 0; i < got_q.size() && i < 6; i++)
            check("t4_data", {24'd0, got_q[i]}, 32'h10 + i);

        // Full depth with a start pulse mid-burst that must be ignored.
        start_burst(7, 16);
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1;
        base_addr = 4'd0;
        len = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(60, 1'b0);
        check("t5_beats", got_q.size(), 32'd16);
        for (int i = 0; i < got_q.size() && i < 16; i++)
            check("t5_data", {24'd0, got_q[i]}, {24'd0, mem_m[(7 + i) % DEPTH]});
        check("t5_last_word", {24'd0, got_q[got_q.size() - 1]}, 32'h16);
        repeat (3) begin @(posedge clk); #1; end
        check("t5_no_queued_start", {31'd0, busy}, 32'd0);
        check("t5_single_done", done_cnt, d0 + 1);

        // Reset mid-burst after two beats.
        start_burst(0, 8);
        for (int k = 0; k < 20 && got_q.size() < 2; k++) begin
            @(posedge clk); #1;
        end
        check("t6_two_beats", got_q.size(), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_ram_addr", {28'd0, ram_addr}, 32'd0);
        check("t6_m_data", {24'd0, m_if.m_data}, 32'd0);
        check("t6_m_valid", {31'd0, m_if.m_valid}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done_tick}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("t6_no_done", done_cnt, d0);
        check("t6_still_idle", {31'd0, busy}, 32'd0);
        start_burst(5, 2);
        wait_done(30, 1'b0);
        check("t6_beats", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            check("t6_w0", {24'd0, got_q[0]}, 32'h15);
            check("t6_w1", {24'd0, got_q[1]}, 32'h16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Sequential burst reader for the team's single-port asynchronous-read RAM: given a start address and a word count, it walks the RAM address port and streams the words out on a valid/ready interface. It is the read-side companion to the RAM's write port. It sits between a RAM instance and any downstream consumer, such as a UART TX or display pipeline. One word per cycle is sustained while the consumer is ready.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM address width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  burst request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address of the burst; sampled with start.
- len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH; sampled with start.
- ram_addr  out  ADDR_WIDTH  address driven to the RAM `addr` input.
- ram_dout  in  DATA_WIDTH  RAM asynchronous read data, valid in the same cycle as ram_addr.
- m_data  out  DATA_WIDTH  output word (registered).
- m_valid  out  1  m_data holds an unconsumed word.
- m_ready  in  1  consumer accepts m_data when m_valid && m_ready at the rising edge.
- busy  out  1  high in every state except IDLE.
- done_tick  out  1  one-cycle pulse when the burst completes.

## Operation
- The system must grant the RAM address port to this block while busy=1. The block never writes the RAM.
- Registers:
  - addr_reg (ADDR_WIDTH)
  - rem_reg (ADDR_WIDTH+1)
  - data_reg (DATA_WIDTH)
  - valid_reg
  - state
- ram_addr = addr_reg at all times. m_data = data_reg. m_valid = valid_reg.
- FSM states: IDLE, READ, DRAIN, DONE.
  - **IDLE**: if start=1, load addr_reg←base_addr and rem_reg←len. If len=0, go to DONE; otherwise go to READ. If start=0, stay.
  - **READ**: slot_free = !valid_reg || m_ready.
    - If slot_free: data_reg←ram_dout, valid_reg←1, addr_reg←addr_reg+1 (mod 2**ADDR_WIDTH, wraps silently), rem_reg←rem_reg−1.
    - If rem_reg=1 at that load, go to DRAIN.
    - If !slot_free: hold all registers.
  - **DRAIN**: when valid_reg && m_ready, clear valid_reg and go to DONE.
  - **DONE**: assert done_tick for exactly one cycle, then go to IDLE.
- In any state other than READ, a handshake (valid_reg && m_ready) clears valid_reg. In READ, a simultaneous handshake and load leaves valid_reg=1 (back-to-back beats).
- start is ignored while busy=1. It is not queued.
- len=2**ADDR_WIDTH reads every location exactly once, starting at base_addr and wrapping.
- m_data must stay stable while m_valid=1 and m_ready=0.

## Timing
- Reset (asynchronous, immediate): state=IDLE, addr_reg=0, rem_reg=0, data_reg=0, valid_reg=0. Therefore ram_addr=0, m_data=0, m_valid=0, busy=0, done_tick=0.
- Reset mid-burst aborts the burst. Any pending word is dropped, and no done_tick is generated.
- Start latency: start is high before edge E0. busy=1 after E0. The first word is loaded at E1, so m_valid=1 after E1.
- Throughput: with m_ready held high, one word per cycle. For a burst of N≥1 words, the last word is accepted at edge E(N+1), and done_tick is high in the cycle after E(N+1).
- len=0: busy=1 and done_tick=1 in the cycle after E0. m_valid never rises.
- Backpressure adds exactly one cycle per stalled cycle. No word is lost or duplicated.
- A new start may be accepted in the first IDLE cycle after DONE.

## Structure
- Shared package/header: FSM state encoding constants (IDLE, READ, DRAIN, DONE; 2-bit). This lets benches and future burst blocks share them.
- Single module. No sub-module is required in RTL.
- The testbench instantiates the team's existing single-port asynchronous-read RAM (`xilinx_one_port_ram_async`) as the memory model. It muxes `addr` between a bench writer and ram_addr according to busy.

## Test plan
- **Preload and full-rate burst**: preload RAM[i]=i+0x10 for ADDR_WIDTH=4, DATA_WIDTH=8. Issue start with base=3, len=5, m_ready=1. Required: m_data 0x13,0x14,0x15,0x16,0x17 on consecutive cycles; done_tick exactly one cycle after the last beat; busy spans start to done.
- **Wrap-around**: base=14, len=4 on a 16-deep RAM. Required: words from addresses 14,15,0,1 in order.
- **Zero length**: len=0. Required: done_tick in the cycle after start, m_valid stays 0, busy high for exactly one cycle.
- **Backpressure**: base=0, len=6 with m_ready toggling 1,0,0,1,0,1…. Required: all 6 words are delivered once and in order, and m_data is stable during stalls.
- **Full-depth burst with ignored start**: len=16. Required: 16 words in order; a second start pulsed mid-burst is ignored.
- **Reset mid-burst**: assert reset after beat 2 of len=8. Required: all outputs are 0 immediately; no done_tick; a subsequent base=5, len=2 burst returns RAM[5], RAM[6].
